// File: rtl/preamble_detect_ctrl.sv
// rtl/preamble_detect_ctrl.sv - preamble detection sequencer gating the adaptive threshold filter
module preamble_detect_ctrl #(
   parameter int DATA_SIZE = 16,
   parameter int HIT_NUM   = 8,
   parameter int MAX_MISS  = 2,
   parameter int HOLDOFF   = 64,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [DATA_SIZE-1:0] in_mag,
   input  logic [DATA_SIZE-1:0] porog_in,
   input  logic [CNT_W-1:0]     frame_len,
   input  logic                 frame_abort,
   output logic                 filt_en,
   output logic                 detect,
   output logic                 frame_active,
   output logic [CNT_W-1:0]     sample_idx,
   output logic [1:0]           state_o
);

   localparam int HIT_W  = $clog2(HIT_NUM + 1);
   localparam int MISS_W = $clog2(MAX_MISS + 2);
   localparam int HOLD_W = $clog2(HOLDOFF + 1);

   localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(HIT_NUM - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISS);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_ARM     = 2'd1,
      S_LOCK    = 2'd2,
      S_HOLDOFF = 2'd3
   } state_t;

   state_t              state;
   logic [HIT_W-1:0]    hit_cnt;
   logic [MISS_W-1:0]   miss_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [CNT_W-1:0]    len_reg;
   logic [CNT_W-1:0]    last_idx;
   logic                hit;

   assign hit      = in_valid & (in_mag > porog_in);
   assign last_idx = (len_reg == '0) ? '0 : len_reg - 1'b1;
   assign filt_en  = en & in_valid & (state != S_LOCK);
   assign state_o  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_SEARCH;
         hit_cnt      <= '0;
         miss_cnt     <= '0;
         hold_cnt     <= '0;
         len_reg      <= '0;
         detect       <= 1'b0;
         frame_active <= 1'b0;
         sample_idx   <= '0;
      end else begin
         detect <= 1'b0;
         if (!en) begin
            state        <= S_SEARCH;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            hold_cnt     <= '0;
            frame_active <= 1'b0;
            sample_idx   <= '0;
         end else begin
            case (state)
               // hit_cnt is always 0 in SEARCH, so one compare covers HIT_NUM=1 too
               S_SEARCH, S_ARM: begin
                  if (hit) begin
                     if (hit_cnt == HIT_LAST) begin
                        state        <= S_LOCK;
                        detect       <= 1'b1;
                        frame_active <= 1'b1;
                        len_reg      <= frame_len;
                        sample_idx   <= '0;
                        hit_cnt      <= '0;
                        miss_cnt     <= '0;
                     end else begin
                        state   <= S_ARM;
                        hit_cnt <= hit_cnt + 1'b1;
                     end
                  end else if (in_valid && state == S_ARM) begin
                     if (miss_cnt == MISS_LAST) begin
                        state    <= S_SEARCH;
                        hit_cnt  <= '0;
                        miss_cnt <= '0;
                     end else begin
                        miss_cnt <= miss_cnt + 1'b1;
                     end
                  end
               end
               S_LOCK: begin
                  if (frame_abort) begin
                     state        <= S_HOLDOFF;
                     frame_active <= 1'b0;
                     hold_cnt     <= '0;
                  end else if (in_valid) begin
                     if (sample_idx == last_idx) begin
                        state        <= S_HOLDOFF;
                        frame_active <= 1'b0;
                        hold_cnt     <= '0;
                     end else begin
                        sample_idx <= sample_idx + 1'b1;
                     end
                  end
               end
               S_HOLDOFF: begin
                  if (in_valid) begin
                     if (hold_cnt == HOLD_LAST) begin
                        state    <= S_SEARCH;
                        hold_cnt <= '0;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
               end
               default: state <= S_SEARCH;
            endcase
         end
      end
   end

endmodule
